// File: rtl/seq_pkg.sv
// Shared definitions for the 1101 sync-framed serial link (transmitter and detector bench).
// SEQ_FRAME_TX_PARITY_EN adds the PARITY state to the transmitter state set.
package seq_pkg;

`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD, ST_PARITY, ST_GAP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD, ST_GAP} state_t;
`endif

  localparam int SYNC_W = 4;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1101;

  function automatic int frame_len(input int data_w, input bit parity_en);
    return SYNC_W + data_w + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/seq_shift_out.sv
// Loadable MSB-first shift register with a count of bits shifted out and a last-bit flag.
module seq_shift_out #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              clr,
  output logic              msb,
  output logic [CNT_W-1:0]  cnt,
  output logic              last
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt + 1'b1;
    end else if (clr) begin
      cnt <= '0;
    end
  end

  assign msb  = sr[DATA_W-1];
  // High while the bit about to be shifted out is the final payload bit.
  assign last = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync 1101, payload MSB-first, optional even parity, idle gap.
// Define SEQ_FRAME_TX_PARITY_EN to append the parity bit after the payload.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int CNT_W        = $clog2(DATA_W + 1);
  localparam int PAYLOAD_BITS = frame_len(DATA_W, 1'b0) - SYNC_W;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

  state_t           state;
  logic [3:0]       ph;
  logic             ld, sh, clr, pay_done;
  logic             msb, last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_idx;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic             par;
`endif

  // State reflects the bit currently on the line; ph indexes sync bits and gap cycles.
  assign in_ready = (state == ST_IDLE);
  assign pay_done = (cnt == CNT_W'(PAYLOAD_BITS));
  assign sync_idx = 2'(SYNC_W - 1) - ph[1:0];
  assign ld       = in_ready && in_valid;
  assign sh       = ((state == ST_SYNC) && (ph == 4'(SYNC_W))) ||
                    ((state == ST_PAYLOAD) && !pay_done);
  assign clr      = (state == ST_PAYLOAD) && pay_done;

  seq_shift_out #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .load_data (in_data),
    .shift     (sh),
    .clr       (clr),
    .msb       (msb),
    .cnt       (cnt),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ph        <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state     <= ST_SYNC;
            ph        <= 4'd1;
            out       <= SYNC_PATTERN[SYNC_W-1];
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par       <= ^in_data;
`endif
          end
        end
        ST_SYNC: begin
          if (ph == 4'(SYNC_W)) begin
            state <= ST_PAYLOAD;
            out   <= msb;
            done  <= last && !PARITY_EN;
          end else begin
            out <= SYNC_PATTERN[sync_idx];
            ph  <= ph + 4'd1;
          end
        end
        ST_PAYLOAD: begin
          if (pay_done) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
            state <= ST_PARITY;
            out   <= par;
            done  <= 1'b1;
`else
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ph        <= 4'd1;
            state     <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            busy      <= (GAP_CYCLES != 0);
`endif
          end else begin
            out  <= msb;
            done <= last && !PARITY_EN;
          end
        end
`ifdef SEQ_FRAME_TX_PARITY_EN
        ST_PARITY: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
          ph        <= 4'd1;
          state     <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          busy      <= (GAP_CYCLES != 0);
        end
`endif
        ST_GAP: begin
          if (ph == GAP_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            ph <= ph + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx with a queue of expected line bits and done flags.
module tb_seq_frame_tx;

  localparam int DW  = 8;
  localparam int GAP = 2;
`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F = 4 + DW + PB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, out, out_valid, busy, done;

  typedef struct packed {logic b; logic d;} exp_t;
  exp_t expq[$];

  int   checks = 0, errors = 0;
  int   cyc = 0, hs_count = 0, hs_cyc = 0, bits_seen = 0, done_cyc = -1, sync_hits = 0;
  int   h1, h2, base;
  bit   mon_en = 1'b0;
  logic [3:0] hist = 4'b0;

  seq_frame_tx #(.DATA_W(DW), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
      hs_count++;
      hs_cyc = cyc;
    end
  end

  // Line monitor: every frame bit is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n === 1'b1) begin
      hist = {hist[2:0], out};
      if (hist == 4'b1101) sync_hits++;
      if (out_valid === 1'b1) begin
        chk("frame_bit_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("out_bit", 32'(out), 32'(e.b));
          chk("done_flag", 32'(done), 32'(e.d));
          bits_seen++;
          if (done === 1'b1) done_cyc = cyc;
        end
      end else begin
        chk("idle_line", {30'b0, out, done}, 0);
      end
    end
  end

  task automatic push_frame(input logic [DW-1:0] w);
    logic [3:0] s;
    s = 4'b1101;
    for (int i = 3; i >= 0; i--) expq.push_back('{b: s[i], d: 1'b0});
    for (int i = DW - 1; i >= 0; i--) expq.push_back('{b: w[i], d: (i == 0 && PB == 0)});
    if (PB != 0) expq.push_back('{b: ^w, d: 1'b1});
  endtask

  task automatic wait_hs();
    int tgt;
    tgt = hs_count + 1;
    for (int i = 0; i < 60 && hs_count < tgt; i++) begin
      @(posedge clk);
      #1;
    end
    chk("handshake_seen", 32'(hs_count >= tgt), 1);
  endtask

  task automatic send(input logic [DW-1:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    push_frame(w);
    wait_hs();
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && !(expq.size() == 0 && in_ready === 1'b1); i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_idle", {30'b0, expq.size() == 0, in_ready}, 32'b11);
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #7 rst_n = 1'b0;
    #1 chk("reset_outputs", {27'b0, out, out_valid, busy, in_ready, done}, 32'b00010);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single frame and gap timing.
    send(8'hA5);
    for (int i = 0; i < 40 && done_cyc < 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("done_seen", 32'(done_cyc >= 0), 1);
    @(negedge clk); #1 chk("gap1", {30'b0, in_ready, out_valid}, 0);
    @(negedge clk); #1 chk("gap2", {30'b0, in_ready, out_valid}, 0);
    @(negedge clk); #1 chk("ready_after_gap", 32'(in_ready), 1);
    drain();

    // Back-to-back with in_valid held and in_data changed mid-frame.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    push_frame(8'h3C);
    wait_hs();
    h1 = hs_cyc;
    in_data = 8'hC3;
    push_frame(8'hC3);
    wait_hs();
    h2 = hs_cyc;
    in_valid = 1'b0;
    in_data  = 8'hFF;
    chk("b2b_spacing", 32'(h2 - h1), 32'(F + GAP + 1));
    drain();

    // Reset after six frame bits, then a clean frame.
    base = bits_seen;
    send(8'h5A);
    for (int i = 0; i < 40 && bits_seen < base + 6; i++) begin
      @(negedge clk);
      #1;
    end
    chk("six_bits_out", 32'(bits_seen - base), 6);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset_outputs", {27'b0, out, out_valid, busy, in_ready, done}, 32'b00010);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h96);
    drain();

    // Loopback: one sync match per frame on the line.
    #1 sync_hits = 0;
    send(8'h00);
    drain();
    chk("loop_00_sync", 32'(sync_hits), 1);
    sync_hits = 0;
    send(8'hFF);
    drain();
    chk("loop_ff_sync", 32'(sync_hits), 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
    send(8'hA5);
    drain();
    send(8'h07);
    drain();
`endif

    chk("queue_empty", 32'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
